// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe_if
//  Description : Handshake/bus bundle for the pipelined immediate generator.
//                Upstream side : in_valid / in_ready / instruction / in_tag
//                Downstream    : out_valid / out_ready / ext_imm / imm_type /
//                                illegal / out_tag
//                Modports:
//                  slave  - the immediate generator itself
//                  master - the environment that feeds and drains it
//  Revision    : 1.0 - initial release
// ============================================================================
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    // upstream (fetch side)
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        instruction;
    logic [TAG_W-1:0]   in_tag;

    // downstream (register-read side)
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    ext_imm;
    logic [2:0]         imm_type;
    logic               illegal;
    logic [TAG_W-1:0]   out_tag;

    modport slave (
        input  in_valid,
        output in_ready,
        input  instruction,
        input  in_tag,
        output out_valid,
        input  out_ready,
        output ext_imm,
        output imm_type,
        output illegal,
        output out_tag
    );

    modport master (
        output in_valid,
        input  in_ready,
        output instruction,
        output in_tag,
        input  out_valid,
        output out_ready,
        input  ext_imm,
        input  imm_type,
        input  illegal,
        input  out_tag
    );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe
//  Description : Pipelined RV32I/RV64I immediate generator for the decode
//                stage. Decodes I, S, B, U, J, shift-amount and (optionally)
//                CSR zimm immediates, extends them to XLEN, and presents them
//                through a valid/ready output stage backed by a 2-entry skid
//                buffer so the upstream ready comes straight from a flop.
//
//  Parameters  : XLEN  - output datapath width (32 or 64)
//                TAG_W - sideband tag width, passed through unchanged
//  Ports       : clk   - clock, rising edge
//                rst   - asynchronous active-high reset
//                flush - synchronous flush, drops every held entry and wins
//                        over a same-cycle accept
//                bus   - imm_gen_pipe_if.slave (handshakes + data)
//  Options     : define IMM_GEN_CSR_EN to decode SYSTEM/CSR zimm immediates;
//                without it every SYSTEM opcode is reported illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       flush,
    imm_gen_pipe_if.slave   bus
);

    // ------------------------------------------------------------------
    // Opcodes and format codes
    // ------------------------------------------------------------------
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] c_TYPE_NONE = 3'd0;
    localparam logic [2:0] c_TYPE_I    = 3'd1;
    localparam logic [2:0] c_TYPE_S    = 3'd2;
    localparam logic [2:0] c_TYPE_B    = 3'd3;
    localparam logic [2:0] c_TYPE_U    = 3'd4;
    localparam logic [2:0] c_TYPE_J    = 3'd5;
    localparam logic [2:0] c_TYPE_SH   = 3'd6;
`ifdef IMM_GEN_CSR_EN
    localparam logic [2:0] c_TYPE_Z    = 3'd7;
`endif

    // One held entry: decoded immediate plus its sideband.
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       typ;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    // Every format is first assembled as a 32-bit sign-correct value and
    // then widened, which keeps the XLEN=32 and XLEN=64 paths identical.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = '0;
        r[31:0] = v;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [31:0] w_inst;
    logic [2:0]  w_funct3;
    entry_t      w_new;

    assign w_inst   = bus.instruction;
    assign w_funct3 = w_inst[14:12];

    always_comb begin
        w_new         = '0;
        w_new.tag     = bus.in_tag;
        w_new.typ     = c_TYPE_NONE;
        w_new.illegal = 1'b0;

        case (w_inst[6:0])
            c_OP_LOAD, c_OP_JALR: begin
                w_new.imm = sext32({{20{w_inst[31]}}, w_inst[31:20]});
                w_new.typ = c_TYPE_I;
            end
            c_OP_IMM: begin
                // SLLI/SRLI/SRAI carry a shift amount, not a signed immediate;
                // RV64 uses the 6-bit shamt, RV32 the 5-bit one.
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    if (XLEN == 64) begin
                        w_new.imm = zext32({26'b0, w_inst[25:20]});
                    end else begin
                        w_new.imm = zext32({27'b0, w_inst[24:20]});
                    end
                    w_new.typ = c_TYPE_SH;
                end else begin
                    w_new.imm = sext32({{20{w_inst[31]}}, w_inst[31:20]});
                    w_new.typ = c_TYPE_I;
                end
            end
            c_OP_STORE: begin
                w_new.imm = sext32({{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]});
                w_new.typ = c_TYPE_S;
            end
            c_OP_BRANCH: begin
                w_new.imm = sext32({{19{w_inst[31]}}, w_inst[31], w_inst[7],
                                    w_inst[30:25], w_inst[11:8], 1'b0});
                w_new.typ = c_TYPE_B;
            end
            c_OP_LUI, c_OP_AUIPC: begin
                w_new.imm = sext32({w_inst[31:12], 12'b0});
                w_new.typ = c_TYPE_U;
            end
            c_OP_JAL: begin
                w_new.imm = sext32({{11{w_inst[31]}}, w_inst[31], w_inst[19:12],
                                    w_inst[20], w_inst[30:21], 1'b0});
                w_new.typ = c_TYPE_J;
            end
            c_OP_SYSTEM: begin
`ifdef IMM_GEN_CSR_EN
                // funct3[2] selects the CSR*I forms whose rs1 field is zimm;
                // the register forms and ECALL/EBREAK carry no immediate but
                // are still legal instructions.
                if (w_funct3[2]) begin
                    w_new.imm = zext32({27'b0, w_inst[19:15]});
                    w_new.typ = c_TYPE_Z;
                end
`else
                w_new.illegal = 1'b1;
`endif
            end
            default: begin
                w_new.illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register + skid register
    // ------------------------------------------------------------------
    entry_t r_main;
    entry_t r_skid;
    logic   r_main_valid;
    logic   r_skid_valid;
    logic   r_in_ready;

    logic   w_accept;
    logic   w_drain;

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_drain  = r_main_valid & bus.out_ready;

    // in_ready is only ever low while the skid entry is held, so an accept
    // and a skid-to-main move can never occur in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_drain && r_skid_valid) begin
            r_main       <= r_skid;
            r_main_valid <= 1'b1;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (!r_main_valid || w_drain) begin
            // Main register free this cycle: the new entry (if any) goes
            // straight in, giving back-to-back transfers with no bubble.
            r_main_valid <= w_accept;
            if (w_accept) begin
                r_main <= w_new;
            end
        end else if (w_accept) begin
            // Main register stalled: park the entry and close the input.
            r_skid       <= w_new;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_main_valid;
    assign bus.ext_imm   = r_main.imm;
    assign bus.imm_type  = r_main.typ;
    assign bus.illegal   = r_main.illegal;
    assign bus.out_tag   = r_main.tag;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_gen_pipe
//  Description : Self-checking bench for imm_gen_pipe. Runs an XLEN=32 and an
//                XLEN=64 instance side by side on the same stimulus: a table
//                of known decodes, handwritten backpressure / flush / reset
//                sequences, and a randomized run against a queue-based
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [31:0]   instruction;
    logic [TW-1:0] in_tag;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(TW)) bus32();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(TW)) bus64();

    assign bus32.in_valid    = in_valid;
    assign bus32.instruction = instruction;
    assign bus32.in_tag      = in_tag;
    assign bus32.out_ready   = out_ready;
    assign bus64.in_valid    = in_valid;
    assign bus64.instruction = instruction;
    assign bus64.in_tag      = in_tag;
    assign bus64.out_ready   = out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TW)) u_dut32 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TW)) u_dut64 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus64)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the entries the block should be holding, oldest first.
    typedef struct {
        logic [31:0]   inst;
        logic [TW-1:0] tag;
    } mentry_t;
    mentry_t mq[$];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Immediate computed from field values with plain integer arithmetic.
    function automatic void ref_decode(input logic [31:0] inst, input int xlen,
                                       output logic [63:0] imm, output logic [2:0] typ,
                                       output logic ill);
        longint u, v;
        int     op, f3;
        u   = longint'({32'b0, inst});
        op  = int'(u % 128);
        f3  = int'((u / 4096) % 8);
        v   = 0;
        typ = 3'd0;
        ill = 1'b0;
        case (op)
            'h03, 'h67: begin
                v = u >> 20; if (v >= 2048) v -= 4096; typ = 3'd1;
            end
            'h13: begin
                if (f3 == 1 || f3 == 5) begin
                    v = (u >> 20) % ((xlen == 64) ? 64 : 32); typ = 3'd6;
                end else begin
                    v = u >> 20; if (v >= 2048) v -= 4096; typ = 3'd1;
                end
            end
            'h23: begin
                v = (u >> 25) * 32 + ((u >> 7) % 32);
                if (v >= 2048) v -= 4096;
                typ = 3'd2;
            end
            'h63: begin
                v = ((u >> 31) % 2) * 4096 + ((u >> 7) % 2) * 2048
                  + ((u >> 25) % 64) * 32 + ((u >> 8) % 16) * 2;
                if (v >= 4096) v -= 8192;
                typ = 3'd3;
            end
            'h37, 'h17: begin
                v = (u >> 12) * 4096;
                if (v >= 64'sd2147483648) v -= 64'sd4294967296;
                typ = 3'd4;
            end
            'h6F: begin
                v = ((u >> 31) % 2) * 1048576 + ((u >> 12) % 256) * 4096
                  + ((u >> 20) % 2) * 2048 + ((u >> 21) % 1024) * 2;
                if (v >= 1048576) v -= 2097152;
                typ = 3'd5;
            end
            'h73: begin
`ifdef IMM_GEN_CSR_EN
                if (f3 >= 4) begin
                    v = (u >> 15) % 32; typ = 3'd7;
                end
`else
                ill = 1'b1;
`endif
            end
            default: ill = 1'b1;
        endcase
        imm = 64'(v);
        if (xlen == 32) imm = imm & 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic void check_model();
        logic [63:0] e_imm;
        logic [2:0]  e_t;
        logic        e_i;
        chk("valid32",   64'(bus32.out_valid), 64'(mq.size() > 0));
        chk("inready32", 64'(bus32.in_ready),  64'(mq.size() < 2));
        chk("valid64",   64'(bus64.out_valid), 64'(mq.size() > 0));
        chk("inready64", 64'(bus64.in_ready),  64'(mq.size() < 2));
        if (mq.size() > 0) begin
            ref_decode(mq[0].inst, 32, e_imm, e_t, e_i);
            chk("imm32",  64'(bus32.ext_imm),  e_imm);
            chk("type32", 64'(bus32.imm_type), 64'(e_t));
            chk("ill32",  64'(bus32.illegal),  64'(e_i));
            chk("tag32",  64'(bus32.out_tag),  64'(mq[0].tag));
            ref_decode(mq[0].inst, 64, e_imm, e_t, e_i);
            chk("imm64",  64'(bus64.ext_imm),  e_imm);
            chk("type64", 64'(bus64.imm_type), 64'(e_t));
            chk("ill64",  64'(bus64.illegal),  64'(e_i));
            chk("tag64",  64'(bus64.out_tag),  64'(mq[0].tag));
        end
    endfunction

    function automatic void check_reset_values(input string where);
        chk({where, "_valid32"}, 64'(bus32.out_valid), 64'd0);
        chk({where, "_ready32"}, 64'(bus32.in_ready),  64'd1);
        chk({where, "_imm32"},   64'(bus32.ext_imm),   64'd0);
        chk({where, "_type32"},  64'(bus32.imm_type),  64'd0);
        chk({where, "_ill32"},   64'(bus32.illegal),   64'd0);
        chk({where, "_tag32"},   64'(bus32.out_tag),   64'd0);
        chk({where, "_valid64"}, 64'(bus64.out_valid), 64'd0);
        chk({where, "_ready64"}, 64'(bus64.in_ready),  64'd1);
        chk({where, "_imm64"},   64'(bus64.ext_imm),   64'd0);
        chk({where, "_tag64"},   64'(bus64.out_tag),   64'd0);
    endfunction

    // One clock: check outputs against the model mid-cycle, then advance the
    // model across the rising edge. Returns 1 time unit after that edge.
    task automatic step();
        bit acc, drn, fl;
        @(negedge clk);
        check_model();
        fl  = flush;
        acc = in_valid && (mq.size() < 2) && !fl;
        drn = (mq.size() > 0) && out_ready;
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back('{instruction, in_tag});
        end
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [12];
        logic [6:0] op;
        ops = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h0B, 7'h33, 7'h00};
        op  = ops[$urandom_range(0, 11)];
        if (op == 7'h00) op = 7'($urandom_range(0, 127));
        return ($urandom() & 32'hFFFF_FF80) | {25'b0, op};
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic [63:0] e32;
        logic [63:0] e64;
        logic [2:0]  typ;
        logic        ill;
    } vec_t;
    vec_t vt [9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0] = '{32'hFFF00093, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0};
        vt[1] = '{32'hFE20AE23, 64'h0000_0000_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0};
        vt[2] = '{32'h123450B7, 64'h0000_0000_1234_5000, 64'h0000_0000_1234_5000, 3'd4, 1'b0};
        vt[3] = '{32'h001000EF, 64'h0000_0000_0000_0800, 64'h0000_0000_0000_0800, 3'd5, 1'b0};
        vt[4] = '{32'h03F09093, 64'h0000_0000_0000_001F, 64'h0000_0000_0000_003F, 3'd6, 1'b0};
        vt[5] = '{32'h0000000B, 64'h0,                   64'h0,                   3'd0, 1'b1};
        vt[6] = '{32'hFE000EE3, 64'h0000_0000_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0};
        vt[7] = '{32'h00C08067, 64'h0000_0000_0000_000C, 64'h0000_0000_0000_000C, 3'd1, 1'b0};
`ifdef IMM_GEN_CSR_EN
        vt[8] = '{32'h3400D073, 64'h1, 64'h1, 3'd7, 1'b0};
`else
        vt[8] = '{32'h3400D073, 64'h0, 64'h0, 3'd0, 1'b1};
`endif

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instruction = 32'h0; in_tag = '0;
        @(posedge clk); #1;
        check_reset_values("reset");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // ---- known decodes, back-to-back with out_ready high ----
        for (int i = 0; i < 9; i++) begin
            in_valid    = 1'b1;
            instruction = vt[i].inst;
            in_tag      = TW'(i + 1);
            out_ready   = 1'b1;
            step();
            chk("tbl_valid", 64'(bus32.out_valid), 64'd1);
            chk("tbl_imm32", 64'(bus32.ext_imm), vt[i].e32);
            chk("tbl_imm64", 64'(bus64.ext_imm), vt[i].e64);
            chk("tbl_type",  64'(bus32.imm_type), 64'(vt[i].typ));
            chk("tbl_type64", 64'(bus64.imm_type), 64'(vt[i].typ));
            chk("tbl_ill",   64'(bus32.illegal), 64'(vt[i].ill));
        end
        in_valid = 1'b0;
        step();

        // ---- backpressure: tags 1,2,3 offered while out_ready is low ----
        out_ready = 1'b0; in_valid = 1'b1; instruction = 32'h00100093;
        in_tag = TW'(1); step();
        chk("bp_ready_after1", 64'(bus32.in_ready), 64'd1);
        in_tag = TW'(2); step();
        chk("bp_ready_after2", 64'(bus32.in_ready), 64'd0);
        chk("bp_head1", 64'(bus32.out_tag), 64'd1);
        in_tag = TW'(3); step();
        chk("bp_held_ready", 64'(bus32.in_ready), 64'd0);
        chk("bp_stable_tag", 64'(bus32.out_tag), 64'd1);
        out_ready = 1'b1; step();
        chk("bp_out2", 64'(bus32.out_tag), 64'd2);
        step();
        chk("bp_out3", 64'(bus32.out_tag), 64'd3);
        chk("bp_out3_valid", 64'(bus32.out_valid), 64'd1);
        in_valid = 1'b0; step();
        chk("bp_empty", 64'(bus32.out_valid), 64'd0);

        // ---- flush with skid full plus an offer ----
        out_ready = 1'b0; in_valid = 1'b1;
        in_tag = TW'(30); step();
        in_tag = TW'(31); step();
        flush = 1'b1; in_tag = TW'(32); step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_full_valid", 64'(bus32.out_valid), 64'd0);
        chk("flush_full_ready", 64'(bus32.in_ready),  64'd1);
        // flush with only main full, while an accept is possible
        in_valid = 1'b1; in_tag = TW'(33); step();
        flush = 1'b1; in_tag = TW'(34); step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_main_valid", 64'(bus32.out_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("flush_no_ghost", 64'(bus64.out_valid), 64'd0);
        end

        // ---- asynchronous reset during a stalled transfer ----
        out_ready = 1'b0; in_valid = 1'b1; instruction = 32'hFFF00093;
        in_tag = TW'(20); step();
        in_tag = TW'(21); step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_values("async_rst");
        mq.delete();
        @(negedge clk); rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_no_stale", 64'(bus32.out_valid), 64'd0);
        end

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 3000; n++) begin
            in_valid    = ($urandom_range(0, 9) < 7);
            out_ready   = ($urandom_range(0, 9) < 6);
            flush       = ($urandom_range(0, 49) == 0);
            instruction = rand_inst();
            in_tag      = TW'($urandom());
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
